sdcard_rx_data_fifo: RTL and testbench

Receive-side data buffer for the SD card controller. It packs bytes from the SD data-line deserializer into 32-bit little-endian words and stores them in a synchronous FIFO. The FIFO's read side drives the FIFO interface of the DMA controller (`fifo_data_out`, `fifo_read`, `fifo_empty`). It also produces a hold request that lets the card-clock generator pause the bus before the FIFO overflows.

---
 rtl/sdcard_rx_data_fifo_if.sv | 40 ++++
 rtl/sdcard_rx_data_fifo.sv | 110 +++++++++++
 tb/tb_sdcard_rx_data_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_rx_data_fifo_if.sv
// Receive-data FIFO bus: deserializer byte stream in, DMA-facing word read port out.
// The overflow_count_o member exists only when SDCARD_RX_FIFO_STATS_EN is defined.
interface sdcard_rx_data_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_byte_i;
    logic          rx_byte_valid_i;
    logic          rx_block_end_i;
    logic          clear_i;
    logic          fifo_read;
    logic [31:0]   fifo_data_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          rx_hold_o;
    logic          overflow_o;
`ifdef SDCARD_RX_FIFO_STATS_EN
    logic [15:0]   overflow_count_o;
`endif

    // FIFO side
    modport slave (
        input  rx_byte_i, rx_byte_valid_i, rx_block_end_i, clear_i, fifo_read,
        output fifo_data_out, fifo_empty, fifo_full, fifo_level, rx_hold_o, overflow_o
`ifdef SDCARD_RX_FIFO_STATS_EN
        , output overflow_count_o
`endif
    );

    // Deserializer / DMA side
    modport master (
        output rx_byte_i, rx_byte_valid_i, rx_block_end_i, clear_i, fifo_read,
        input  fifo_data_out, fifo_empty, fifo_full, fifo_level, rx_hold_o, overflow_o
`ifdef SDCARD_RX_FIFO_STATS_EN
        , input overflow_count_o
`endif
    );
endinterface

// File: rtl/sdcard_rx_data_fifo.sv
// SD receive buffer: packs bytes into little-endian 32-bit words and queues them in a FWFT FIFO.
// Optional SDCARD_RX_FIFO_STATS_EN adds a saturating dropped-word counter.
module sdcard_rx_data_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                  PCLK_i,
    input  logic                  PRESETn_i,
    sdcard_rx_data_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [1:0]    r_idx;
    logic [23:0]   r_hold;
    logic [31:0]   r_mem [DEPTH];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic          r_overflow;

    logic [31:0]   w_word;
    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic [LW-1:0] w_level;
    logic          w_empty;
    logic          w_full;

    // Word being assembled, including the current byte; bytes above it are zero.
    always_comb begin
        w_word = '0;
        case (r_idx)
            2'd0:    w_word = {24'h0, bus.rx_byte_i};
            2'd1:    w_word = {16'h0, bus.rx_byte_i, r_hold[7:0]};
            2'd2:    w_word = {8'h0, bus.rx_byte_i, r_hold[15:0]};
            default: w_word = {bus.rx_byte_i, r_hold};
        endcase
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LW'(DEPTH));
    assign w_push  = bus.rx_byte_valid_i && ((r_idx == 2'd3) || bus.rx_block_end_i);
    assign w_pop   = !bus.clear_i && bus.fifo_read && !w_empty;
    assign w_wr_en = !bus.clear_i && w_push && (!w_full || w_pop);
    assign w_drop  = !bus.clear_i && w_push && w_full && !w_pop;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            r_idx  <= 2'd0;
            r_hold <= 24'h0;
        end else if (bus.clear_i) begin
            r_idx  <= 2'd0;
            r_hold <= 24'h0;
        end else if (bus.rx_byte_valid_i) begin
            if (w_push) begin
                r_idx  <= 2'd0;
                r_hold <= 24'h0;
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_hold <= w_word[23:0];
            end
        end
    end

    // Storage needs no reset: reads are masked by the empty flag.
    always_ff @(posedge PCLK_i) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + LW'(1);
            if (w_drop)  r_overflow <= 1'b1;
        end
    end

`ifdef SDCARD_RX_FIFO_STATS_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            r_ovf_cnt <= 16'h0;
        end else if (bus.clear_i) begin
            r_ovf_cnt <= 16'h0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign bus.overflow_count_o = r_ovf_cnt;
`endif

    assign bus.fifo_data_out = w_empty ? 32'h0 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.fifo_empty    = w_empty;
    assign bus.fifo_full     = w_full;
    assign bus.fifo_level    = w_level;
    assign bus.rx_hold_o     = (w_level >= LW'(AFULL_THRESH));
    assign bus.overflow_o    = r_overflow;
endmodule

// File: tb/tb_sdcard_rx_data_fifo.sv
// Directed self-checking bench for sdcard_rx_data_fifo (DEPTH=16, AFULL_THRESH=12).
module tb_sdcard_rx_data_fifo;
    logic PCLK_i    = 1'b0;
    logic PRESETn_i = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    sdcard_rx_data_fifo_if #(.DEPTH(16)) bus ();

    sdcard_rx_data_fifo #(.DEPTH(16), .AFULL_THRESH(12)) dut (
        .PCLK_i    (PCLK_i),
        .PRESETn_i (PRESETn_i),
        .bus       (bus)
    );

    always #5 PCLK_i = ~PCLK_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic be, input logic rd);
        bus.rx_byte_i       = b;
        bus.rx_byte_valid_i = 1'b1;
        bus.rx_block_end_i  = be;
        bus.fifo_read       = rd;
        tick();
        bus.rx_byte_valid_i = 1'b0;
        bus.rx_block_end_i  = 1'b0;
        bus.fifo_read       = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0, 1'b0);
    endtask

    task automatic pop();
        bus.fifo_read = 1'b1;
        tick();
        bus.fifo_read = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    function automatic logic [31:0] fw(input int i);
        return {8'h5A, 8'(i), 8'h3C, 8'(i * 3)};
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},  bus.fifo_data_out, 32'h0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 32'd1);
        chk({tag, "_full"},  32'(bus.fifo_full), 32'd0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
        chk({tag, "_hold"},  32'(bus.rx_hold_o), 32'd0);
        chk({tag, "_ovf"},   32'(bus.overflow_o), 32'd0);
    endtask

    logic [31:0] q[$];
    logic [31:0] w;

    initial begin
        bus.rx_byte_i       = 8'h0;
        bus.rx_byte_valid_i = 1'b0;
        bus.rx_block_end_i  = 1'b0;
        bus.clear_i         = 1'b0;
        bus.fifo_read       = 1'b0;

        // Reset
        repeat (3) tick();
        chk_reset_state("reset");
        PRESETn_i = 1'b1;
        tick();

        // Byte packing
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        chk("pack_3bytes_empty", 32'(bus.fifo_empty), 32'd1);
        send_byte(8'h44, 1'b0, 1'b0);
        chk("pack_word", bus.fifo_data_out, 32'h44332211);
        chk("pack_empty", 32'(bus.fifo_empty), 32'd0);
        chk("pack_level", 32'(bus.fifo_level), 32'd1);
        pop();
        chk("pop_to_empty", 32'(bus.fifo_empty), 32'd1);
        chk("pop_data_zero", bus.fifo_data_out, 32'h0);

        // Partial block end, then a fresh word
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        chk("blkend_word", bus.fifo_data_out, 32'h0000BBAA);
        chk("blkend_level", 32'(bus.fifo_level), 32'd1);
        send_byte(8'hCC, 1'b1, 1'b0);
        bus.rx_block_end_i = 1'b1;  // block end without a valid byte is ignored
        tick();
        bus.rx_block_end_i = 1'b0;
        chk("blkend_novalid_level", 32'(bus.fifo_level), 32'd2);
        push_word(32'h04030201);
        chk("after_blkend_level", 32'(bus.fifo_level), 32'd3);
        pop();
        chk("head_cc", bus.fifo_data_out, 32'h000000CC);
        pop();
        chk("fresh_word", bus.fifo_data_out, 32'h04030201);
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b0);
        send_byte(8'hE4, 1'b1, 1'b0);
        chk("blkend_on_4th_level", 32'(bus.fifo_level), 32'd2);
        pop();
        chk("blkend_on_4th_word", bus.fifo_data_out, 32'hE4E3E2E1);
        pop();
        chk("drained", 32'(bus.fifo_empty), 32'd1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            push_word(fw(i));
            chk($sformatf("fill_hold_%0d", i + 1), 32'(bus.rx_hold_o), 32'(i + 1 >= 12));
        end
        chk("fill_full", 32'(bus.fifo_full), 32'd1);
        chk("fill_level", 32'(bus.fifo_level), 32'd16);
        chk("fill_ovf0", 32'(bus.overflow_o), 32'd0);
        push_word(32'hDEADBEEF);
        chk("ovf_flag", 32'(bus.overflow_o), 32'd1);
        chk("ovf_level", 32'(bus.fifo_level), 32'd16);
        chk("ovf_head", bus.fifo_data_out, fw(0));
`ifdef SDCARD_RX_FIFO_STATS_EN
        chk("ovf_count", 32'(bus.overflow_count_o), 32'd1);
`endif

        // Full with simultaneous push and pop
        do_clear();
        chk("clr_ovf", 32'(bus.overflow_o), 32'd0);
        chk("clr_level", 32'(bus.fifo_level), 32'd0);
`ifdef SDCARD_RX_FIFO_STATS_EN
        chk("clr_count", 32'(bus.overflow_count_o), 32'd0);
`endif
        for (int i = 0; i < 16; i++) push_word(fw(i));
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b1);
        chk("pp_full_level", 32'(bus.fifo_level), 32'd16);
        chk("pp_full_ovf", 32'(bus.overflow_o), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp_order_%0d", i), bus.fifo_data_out, fw(i));
            pop();
        end
        chk("pp_last", bus.fifo_data_out, 32'h04030201);
        pop();
        chk("pp_empty", 32'(bus.fifo_empty), 32'd1);

        // Read while empty
        pop();
        chk_reset_state("rd_empty");

        // Clear with level 5 and 2 packed bytes
        for (int i = 0; i < 5; i++) push_word(fw(i));
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0);
        chk("pre_clear_level", 32'(bus.fifo_level), 32'd5);
        bus.clear_i = 1'b1;
        send_byte(8'hA3, 1'b0, 1'b1);
        bus.clear_i = 1'b0;
        chk_reset_state("clear");
        push_word(32'h08070605);
        chk("post_clear_word", bus.fifo_data_out, 32'h08070605);
        chk("post_clear_level", 32'(bus.fifo_level), 32'd1);

        // Asynchronous reset mid-word
        push_word(32'h11111111);
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        #2;
        PRESETn_i = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(negedge PCLK_i);
        PRESETn_i = 1'b1;
        tick();
        push_word(32'h0D0C0B0A);
        chk("post_rst_word", bus.fifo_data_out, 32'h0D0C0B0A);
        pop();

        // Stream 40 words with interleaved pops across pointer wrap
        for (int i = 0; i < 40; i++) begin
            w = 32'hC0DE0000 + 32'(i * 257);
            push_word(w);
            q.push_back(w);
            if (i % 3 != 0) begin
                chk($sformatf("wrap_head_%0d", i), bus.fifo_data_out, q[0]);
                void'(q.pop_front());
                pop();
            end
        end
        chk("wrap_level", 32'(bus.fifo_level), 32'(q.size()));
        while (q.size() > 0) begin
            chk("wrap_drain", bus.fifo_data_out, q[0]);
            void'(q.pop_front());
            pop();
        end
        chk("wrap_empty", 32'(bus.fifo_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
